branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor for the five-stage RISC-V pipeline; generation after fixed not-taken.
- IF-stage side: looks up the fetch PC every cycle and returns a predicted direction and target.
- ID-stage side: receives the resolved branch outcome, updates the predictor, and raises a mispredict/flush request.
- Keeps saturating statistics counters for branches resolved and mispredicted.

---
 rtl/bp_pkg.sv | 31 +++
 rtl/bp_sat_counter.sv | 24 ++
 rtl/branch_predictor.sv | 137 +++++++++++++
 tb/tb_branch_predictor.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared helpers for the dynamic branch predictor: PC field extraction
// and direction-counter constants derived from the counter width.
package bp_pkg;

    // Table index: PC bits [idx_w+1:2]
    function automatic logic [63:0] bp_index(input logic [63:0] pc, input int unsigned idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    // Partial tag: PC bits [idx_w+tag_bits+1:idx_w+2]
    function automatic logic [63:0] bp_tag(input logic [63:0] pc, input int unsigned idx_w,
                                           input int unsigned tag_bits);
        return (pc >> (idx_w + 2)) & ((64'd1 << tag_bits) - 64'd1);
    endfunction

    // Weakly not-taken
    function automatic int unsigned bp_wnt(input int unsigned cnt_bits);
        return (32'd1 << (cnt_bits - 1)) - 32'd1;
    endfunction

    // Weakly taken
    function automatic int unsigned bp_wt(input int unsigned cnt_bits);
        return bp_wnt(cnt_bits) + 32'd1;
    endfunction

    // Strongly taken (saturation ceiling)
    function automatic int unsigned bp_max(input int unsigned cnt_bits);
        return (32'd1 << cnt_bits) - 32'd1;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down next-value logic for one direction counter.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int unsigned CNT_BITS = 2
) (
    input  logic [CNT_BITS-1:0] cur_i,
    input  logic                taken_i,
    output logic [CNT_BITS-1:0] nxt_o
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(bp_max(CNT_BITS));

    // Step toward taken/not-taken, holding at the rails
    always_comb begin
        nxt_o = cur_i;
        if (taken_i) begin
            if (cur_i != CNT_MAX) nxt_o = cur_i + CNT_BITS'(1);
        end else begin
            if (cur_i != '0) nxt_o = cur_i - CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Tagged direction/target predictor: zero-latency lookup for IF,
// resolved-branch update and mispredict flush request from ID,
// plus saturating branch/mispredict statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CNT_BITS = 2,
    parameter int unsigned TAG_BITS = 8,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              pred_taken_o,
    output logic              pred_hit_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [ADDR_W-1:0] upd_pred_target_i,
    output logic              mispredict_o,
    output logic [31:0]       branch_cnt_o,
    output logic [31:0]       mispred_cnt_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'(bp_wnt(CNT_BITS));
    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(bp_wt(CNT_BITS));

    typedef struct packed {
        logic                valid;
        logic [TAG_BITS-1:0] tag;
        logic [ADDR_W-1:0]   target;
        logic [CNT_BITS-1:0] cnt;
    } entry_t;

    entry_t table_q [ENTRIES];

    logic [IDX_W-1:0]    lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    entry_t              lk_ent;

    logic [IDX_W-1:0]    upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    entry_t              upd_ent;
    logic                upd_en;
    logic                upd_hit;
    logic [CNT_BITS-1:0] cnt_nxt;
    entry_t              entry_d;

    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    assign lk_idx  = IDX_W'(bp_index(64'(lookup_pc_i), IDX_W));
    assign lk_tag  = TAG_BITS'(bp_tag(64'(lookup_pc_i), IDX_W, TAG_BITS));
    assign upd_idx = IDX_W'(bp_index(64'(upd_pc_i), IDX_W));
    assign upd_tag = TAG_BITS'(bp_tag(64'(upd_pc_i), IDX_W, TAG_BITS));

    assign lk_ent  = table_q[lk_idx];
    assign upd_ent = table_q[upd_idx];
    assign upd_en  = upd_valid_i & start_i;
    assign upd_hit = upd_ent.valid & (upd_ent.tag == upd_tag);

    // Lookup: hit needs run enable, valid entry and tag match; fall through to pc+4
    always_comb begin
        pred_hit_o    = start_i & lk_ent.valid & (lk_ent.tag == lk_tag);
        pred_taken_o  = pred_hit_o & lk_ent.cnt[CNT_BITS-1];
        pred_target_o = pred_taken_o ? lk_ent.target : lookup_pc_i + ADDR_W'(4);
    end

    // Direction or target disagreement between prediction and resolution
    always_comb begin
        mispredict_o = upd_en &
                       ((upd_taken_i != upd_pred_taken_i) |
                        (upd_taken_i & upd_pred_taken_i & (upd_target_i != upd_pred_target_i)));
    end

    bp_sat_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_sat_counter (
        .cur_i   (upd_ent.cnt),
        .taken_i (upd_taken_i),
        .nxt_o   (cnt_nxt)
    );

    // New contents of the updated entry: train on hit, reallocate on miss
    always_comb begin
        entry_d = upd_ent;
        if (upd_hit) begin
            entry_d.cnt = cnt_nxt;
            if (upd_taken_i) entry_d.target = upd_target_i;
        end else begin
            entry_d.valid  = 1'b1;
            entry_d.tag    = upd_tag;
            entry_d.target = upd_target_i;
            entry_d.cnt    = upd_taken_i ? CNT_WT : CNT_WNT;
        end
    end

    // Table storage; reset takes priority over a same-cycle update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WNT};
            end
        end else if (upd_en) begin
            table_q[upd_idx] <= entry_d;
        end
    end

    // Saturating statistics next-state
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_en && (branch_cnt_q != '1))   branch_cnt_d  = branch_cnt_q + 32'd1;
        if (mispredict_o && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + 32'd1;
    end

    // Statistics registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed + randomized bench for branch_predictor against a table model
// built from plain arrays and integer counter arithmetic.
module tb_branch_predictor;

    localparam int unsigned ENTRIES  = 16;
    localparam int unsigned CNT_BITS = 2;
    localparam int unsigned TAG_BITS = 8;
    localparam int unsigned ADDR_W   = 32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic        pred_hit;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_ptaken;
    logic [31:0] upd_ptarget;
    logic        mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    branch_predictor #(
        .ENTRIES  (ENTRIES),
        .CNT_BITS (CNT_BITS),
        .TAG_BITS (TAG_BITS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .start_i           (start),
        .lookup_pc_i       (lookup_pc),
        .pred_taken_o      (pred_taken),
        .pred_hit_o        (pred_hit),
        .pred_target_o     (pred_target),
        .upd_valid_i       (upd_valid),
        .upd_pc_i          (upd_pc),
        .upd_taken_i       (upd_taken),
        .upd_target_i      (upd_target),
        .upd_pred_taken_i  (upd_ptaken),
        .upd_pred_target_i (upd_ptarget),
        .mispredict_o      (mispredict),
        .branch_cnt_o      (branch_cnt),
        .mispred_cnt_o     (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned mtag(input logic [31:0] pc);
        return int'((pc >> 6) % 256);
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = '0;
            m_cnt[i]   = 1;
        end
        m_bcnt = '0;
        m_mcnt = '0;
    endtask

    task automatic model_predict(input logic [31:0] pc, input bit en,
                                 output bit hit, output bit tk, output logic [31:0] tgt);
        int i;
        i   = midx(pc);
        hit = en && m_valid[i] && (m_tag[i] == mtag(pc));
        tk  = hit && (m_cnt[i] >= 2);
        tgt = tk ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic model_update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        int i;
        i = midx(pc);
        if (m_valid[i] && (m_tag[i] == mtag(pc))) begin
            if (tk) begin
                m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
                m_tgt[i] = tgt;
            end else begin
                m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end
        end else begin
            m_valid[i] = 1'b1;
            m_tag[i]   = mtag(pc);
            m_tgt[i]   = tgt;
            m_cnt[i]   = tk ? 2 : 1;
        end
    endtask

    // One clock: check combinational outputs, advance model at the edge, check stats
    task automatic run_cycle(input bit chk);
        bit          e_hit, e_tk, e_mis, en;
        logic [31:0] e_tgt;
        #1;
        en = upd_valid && start;
        model_predict(lookup_pc, start, e_hit, e_tk, e_tgt);
        e_mis = en && ((upd_taken != upd_ptaken) ||
                       (upd_taken && upd_ptaken && (upd_target != upd_ptarget)));
        if (chk) begin
            check("pred_hit",    32'(pred_hit),   32'(e_hit));
            check("pred_taken",  32'(pred_taken), 32'(e_tk));
            check("pred_target", pred_target,     e_tgt);
            check("mispredict",  32'(mispredict), 32'(e_mis));
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (en) begin
            model_update(upd_pc, upd_taken, upd_target);
            if (m_bcnt != 32'hFFFF_FFFF) m_bcnt = m_bcnt + 32'd1;
            if (e_mis && (m_mcnt != 32'hFFFF_FFFF)) m_mcnt = m_mcnt + 32'd1;
        end
        #1;
        if (chk) begin
            check("branch_cnt",  branch_cnt,  m_bcnt);
            check("mispred_cnt", mispred_cnt, m_mcnt);
        end
        @(negedge clk);
    endtask

    task automatic drive_upd(input bit v, input logic [31:0] pc, input bit tk,
                             input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
        upd_valid   = v;
        upd_pc      = pc;
        upd_taken   = tk;
        upd_target  = tgt;
        upd_ptaken  = ptk;
        upd_ptarget = ptgt;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = (32'($urandom_range(0, 1)) << 20) | (32'($urandom_range(0, 3)) << 6) |
             (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        return pc;
    endfunction

    initial begin
        bit          p_hit, p_tk;
        logic [31:0] p_tgt, pc;

        rst = 1'b1;
        start = 1'b0;
        lookup_pc = 32'h100;
        drive_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        model_reset();
        @(negedge clk);
        run_cycle(1'b0);
        run_cycle(1'b0);
        rst = 1'b0;
        start = 1'b1;

        // Reset state
        run_cycle(1'b1);
        check("rst_hit",    32'(pred_hit),   32'h0);
        check("rst_taken",  32'(pred_taken), 32'h0);
        check("rst_target", pred_target,     32'h104);
        check("rst_bcnt",   branch_cnt,      32'h0);

        // First allocation, mispredicted as not-taken
        drive_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        run_cycle(1'b1);
        drive_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        #1;
        check("alloc_hit",    32'(pred_hit),   32'h1);
        check("alloc_taken",  32'(pred_taken), 32'h1);
        check("alloc_target", pred_target,     32'h80);
        check("alloc_bcnt",   branch_cnt,      32'h1);
        check("alloc_mcnt",   mispred_cnt,     32'h1);
        @(negedge clk);

        // Saturate high then train down
        for (int k = 0; k < 3; k++) begin
            drive_upd(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
            run_cycle(1'b1);
        end
        drive_upd(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        run_cycle(1'b1);
        check("after_nt1_taken", 32'(pred_taken), 32'h1);
        run_cycle(1'b1);
        drive_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        #1;
        check("after_nt2_taken", 32'(pred_taken), 32'h0);
        check("after_nt2_hit",   32'(pred_hit),   32'h1);
        @(negedge clk);

        // Same index, different tag: reallocation
        drive_upd(1'b1, 32'h140, 1'b0, 32'h40, 1'b0, 32'h144);
        run_cycle(1'b1);
        drive_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        #1;
        check("realloc_old_hit", 32'(pred_hit), 32'h0);
        @(negedge clk);

        // Same-cycle lookup and update: no bypass
        lookup_pc = 32'h200;
        drive_upd(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
        run_cycle(1'b1);
        drive_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        #1;
        check("nobypass_next_hit", 32'(pred_hit), 32'h1);
        check("nobypass_next_tgt", pred_target,   32'h300);
        @(negedge clk);

        // Mispredict counter saturation
        force dut.mispred_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.mispred_cnt_q;
        m_mcnt = 32'hFFFF_FFFE;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            drive_upd(1'b1, 32'h200, 1'b0, 32'h300, 1'b1, 32'h300);
            run_cycle(1'b1);
        end
        check("mcnt_sat", mispred_cnt, 32'hFFFF_FFFF);

        // start low: no updates, forced not-taken, no mispredict
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            lookup_pc = (k % 2 == 0) ? 32'h200 : rand_pc();
            drive_upd(1'b1, rand_pc(), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom);
            run_cycle(1'b1);
        end
        start = 1'b1;

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            start = ($urandom_range(0, 9) != 0);
            lookup_pc = rand_pc();
            pc = rand_pc();
            model_predict(pc, 1'b1, p_hit, p_tk, p_tgt);
            if ($urandom_range(0, 3) == 0) p_tk = ~p_tk;
            if ($urandom_range(0, 7) == 0) p_tgt = p_tgt ^ 32'h10;
            drive_upd(1'($urandom_range(0, 2) != 0), pc, 1'($urandom_range(0, 1)),
                      {16'h0, 14'($urandom), 2'b00}, p_tk, p_tgt);
            run_cycle(1'b1);
        end
        start = 1'b1;

        // Reset beats a simultaneous update
        rst = 1'b1;
        lookup_pc = 32'h300;
        drive_upd(1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 32'h304);
        run_cycle(1'b1);
        rst = 1'b0;
        drive_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        run_cycle(1'b1);
        check("rst_upd_hit",  32'(pred_hit), 32'h0);
        check("rst_upd_bcnt", branch_cnt,    32'h0);
        check("rst_upd_mcnt", mispred_cnt,   32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
